// File: rtl/mc_res_gen.sv
// Residual generator: takes MC prediction beats, reads the co-located original pixels,
// and streams lane-wise (ori - pre) residual beats to TQ with a per-TU last flag.
module mc_res_gen #(
    parameter int PIX_W = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start_i,
    input  logic                    ctu_done_i,
    input  logic                    pre_wr_ena_i,
    input  logic [1:0]              pre_wr_sel_i,
    input  logic [1:0]              pre_wr_siz_i,
    input  logic [3:0]              pre_wr_4x4_x_i,
    input  logic [3:0]              pre_wr_4x4_y_i,
    input  logic [32*PIX_W-1:0]     pre_wr_dat_i,
    output logic                    ori_rd_ena_o,
    output logic [1:0]              ori_rd_sel_o,
    output logic [1:0]              ori_rd_siz_o,
    output logic [3:0]              ori_rd_4x4_x_o,
    output logic [3:0]              ori_rd_4x4_y_o,
    input  logic [32*PIX_W-1:0]     ori_rd_dat_i,
    output logic                    res_val_o,
    output logic [1:0]              res_sel_o,
    output logic [1:0]              res_siz_o,
    output logic [3:0]              res_4x4_x_o,
    output logic [3:0]              res_4x4_y_o,
    output logic [32*(PIX_W+1)-1:0] res_dat_o,
    output logic                    res_last_o,
    input  logic                    tq_done_i,
    output logic                    rec_done_o,
    output logic                    err_o
);

    localparam int LANES = 32;
    localparam int RES_W = PIX_W + 1;
    localparam logic [1:0] SIZE_04 = 2'd0;
    localparam logic [1:0] SIZE_08 = 2'd1;
    localparam logic [1:0] SIZE_16 = 2'd2;

    typedef enum logic [1:0] {IDLE, STRM, WAIT} state_t;

    state_t                r_state;
    logic [4:0]            r_cnt;
    logic [1:0]            r_siz;
    logic                  r_rec_done;
    logic                  r_err;

    logic                  r_s1_val;
    logic [1:0]            r_s1_sel;
    logic [1:0]            r_s1_siz;
    logic [3:0]            r_s1_x;
    logic [3:0]            r_s1_y;
    logic                  r_s1_last;
    logic [32*PIX_W-1:0]   r_s1_pre;

    logic                  w_strm;
    logic                  w_acc;
    logic                  w_last;
    logic [1:0]            w_siz;
    logic [4:0]            w_nm1;
    logic [LANES*RES_W-1:0] w_res;

    assign w_strm = (r_state == STRM);
    assign w_acc  = w_strm && pre_wr_ena_i;
    // The first beat of a TU defines its size; later beats reuse the latched value.
    assign w_siz  = (r_cnt == 5'd0) ? pre_wr_siz_i : r_siz;

    always_comb begin
        w_nm1 = 5'd31;
        case (w_siz)
            SIZE_04: w_nm1 = 5'd0;
            SIZE_08: w_nm1 = 5'd1;
            SIZE_16: w_nm1 = 5'd7;
            default: w_nm1 = 5'd31;
        endcase
    end
    assign w_last = (r_cnt == w_nm1);

    assign ori_rd_ena_o   = w_acc;
    assign ori_rd_sel_o   = w_strm ? pre_wr_sel_i   : 2'd0;
    assign ori_rd_siz_o   = w_strm ? pre_wr_siz_i   : 2'd0;
    assign ori_rd_4x4_x_o = w_strm ? pre_wr_4x4_x_i : 4'd0;
    assign ori_rd_4x4_y_o = w_strm ? pre_wr_4x4_y_i : 4'd0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_cnt      <= 5'd0;
            r_siz      <= 2'd0;
            r_rec_done <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rec_done <= 1'b0;
            if (pre_wr_ena_i && !w_strm)
                r_err <= 1'b1;
            else if (start_i && r_state == IDLE)
                r_err <= 1'b0;
            if (w_acc) begin
                if (r_cnt == 5'd0)
                    r_siz <= pre_wr_siz_i;
                r_cnt <= w_last ? 5'd0 : r_cnt + 5'd1;
            end
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state <= STRM;
                        r_cnt   <= 5'd0;
                    end
                end
                STRM: begin
                    if (ctu_done_i) begin
                        r_state <= IDLE;
                        r_cnt   <= 5'd0;
                    end else if (w_acc && w_last) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (ctu_done_i) begin
                        r_state <= IDLE;
                        r_cnt   <= 5'd0;
                    end else if (tq_done_i) begin
                        r_state    <= STRM;
                        r_rec_done <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rec_done_o = r_rec_done;
    assign err_o      = r_err;

    // Subtraction happens in the cycle the original data returns, using stage-1 prediction.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [RES_W-1:0] w_diff;
            assign w_diff = {1'b0, ori_rd_dat_i[gi*PIX_W +: PIX_W]}
                          - {1'b0, r_s1_pre[gi*PIX_W +: PIX_W]};
            if (gi < LANES/2) begin : g_lo
                assign w_res[gi*RES_W +: RES_W] = w_diff;
            end else begin : g_hi
                assign w_res[gi*RES_W +: RES_W] = (r_s1_siz == SIZE_04) ? '0 : w_diff;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_val    <= 1'b0;
            r_s1_sel    <= 2'd0;
            r_s1_siz    <= 2'd0;
            r_s1_x      <= 4'd0;
            r_s1_y      <= 4'd0;
            r_s1_last   <= 1'b0;
            r_s1_pre    <= '0;
            res_val_o   <= 1'b0;
            res_sel_o   <= 2'd0;
            res_siz_o   <= 2'd0;
            res_4x4_x_o <= 4'd0;
            res_4x4_y_o <= 4'd0;
            res_last_o  <= 1'b0;
            res_dat_o   <= '0;
        end else begin
            r_s1_val    <= w_acc;
            r_s1_sel    <= pre_wr_sel_i;
            r_s1_siz    <= w_siz;
            r_s1_x      <= pre_wr_4x4_x_i;
            r_s1_y      <= pre_wr_4x4_y_i;
            r_s1_last   <= w_last;
            r_s1_pre    <= pre_wr_dat_i;
            res_val_o   <= r_s1_val;
            res_sel_o   <= r_s1_sel;
            res_siz_o   <= r_s1_siz;
            res_4x4_x_o <= r_s1_x;
            res_4x4_y_o <= r_s1_y;
            res_last_o  <= r_s1_val && r_s1_last;
            res_dat_o   <= w_res;
        end
    end

endmodule

// File: tb/tb_mc_res_gen.sv
// Directed bench for mc_res_gen: table of TU vectors plus hand sequences for
// WAIT-state errors, ignored tq_done, ctu_done with a live beat, and mid-stream reset.
module tb_mc_res_gen;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         start_i = 1'b0;
    logic         ctu_done_i = 1'b0;
    logic         pre_wr_ena_i = 1'b0;
    logic [1:0]   pre_wr_sel_i = 2'd0;
    logic [1:0]   pre_wr_siz_i = 2'd0;
    logic [3:0]   pre_wr_4x4_x_i = 4'd0;
    logic [3:0]   pre_wr_4x4_y_i = 4'd0;
    logic [255:0] pre_wr_dat_i = '0;
    logic         ori_rd_ena_o;
    logic [1:0]   ori_rd_sel_o;
    logic [1:0]   ori_rd_siz_o;
    logic [3:0]   ori_rd_4x4_x_o;
    logic [3:0]   ori_rd_4x4_y_o;
    logic [255:0] ori_rd_dat_i = '0;
    logic         res_val_o;
    logic [1:0]   res_sel_o;
    logic [1:0]   res_siz_o;
    logic [3:0]   res_4x4_x_o;
    logic [3:0]   res_4x4_y_o;
    logic [287:0] res_dat_o;
    logic         res_last_o;
    logic         tq_done_i = 1'b0;
    logic         rec_done_o;
    logic         err_o;

    mc_res_gen #(.PIX_W(8)) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .ctu_done_i(ctu_done_i),
        .pre_wr_ena_i(pre_wr_ena_i), .pre_wr_sel_i(pre_wr_sel_i), .pre_wr_siz_i(pre_wr_siz_i),
        .pre_wr_4x4_x_i(pre_wr_4x4_x_i), .pre_wr_4x4_y_i(pre_wr_4x4_y_i), .pre_wr_dat_i(pre_wr_dat_i),
        .ori_rd_ena_o(ori_rd_ena_o), .ori_rd_sel_o(ori_rd_sel_o), .ori_rd_siz_o(ori_rd_siz_o),
        .ori_rd_4x4_x_o(ori_rd_4x4_x_o), .ori_rd_4x4_y_o(ori_rd_4x4_y_o), .ori_rd_dat_i(ori_rd_dat_i),
        .res_val_o(res_val_o), .res_sel_o(res_sel_o), .res_siz_o(res_siz_o),
        .res_4x4_x_o(res_4x4_x_o), .res_4x4_y_o(res_4x4_y_o), .res_dat_o(res_dat_o),
        .res_last_o(res_last_o), .tq_done_i(tq_done_i), .rec_done_o(rec_done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sel;
        logic [1:0] siz;
        logic [7:0] pre;
        logic [7:0] ori;
        int         n;
        logic [8:0] lo;
        logic [8:0] hi;
    } vec_t;

    typedef struct {
        logic [12:0]  attr;
        logic [287:0] dat;
        int           due;
    } exp_t;

    int        checks = 0;
    int        errors = 0;
    int        cyc = 0;
    int        rec_due = -1;
    logic [7:0] cur_ori = 8'h00;
    exp_t      q[$];
    exp_t      e_pop;
    vec_t      vecs[7];

    always @(posedge clk) cyc <= cyc + 1;

    // Original-pixel buffer: data appears one cycle after a read, poison otherwise.
    always @(posedge clk)
        ori_rd_dat_i <= ori_rd_ena_o ? {32{cur_ori}} : {32{8'hA5}};

    task automatic chk(input string nm, input logic [287:0] act, input logic [287:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [287:0] mk_dat(input logic [8:0] lo, input logic [8:0] hi);
        logic [287:0] d;
        for (int k = 0; k < 32; k++) d[k*9 +: 9] = (k < 16) ? lo : hi;
        return d;
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            e_pop = q.pop_front();
            chk("res_val", res_val_o, 1'b1);
            chk("res_attr", {res_last_o, res_sel_o, res_siz_o, res_4x4_x_o, res_4x4_y_o}, e_pop.attr);
            chk("res_dat", res_dat_o, e_pop.dat);
            $display("beat cyc=%0d attr=%h val=%0b", cyc, e_pop.attr, res_val_o);
        end else begin
            chk("res_val_idle", res_val_o, 1'b0);
        end
        chk("rec_done", rec_done_o, cyc == rec_due);
    end

    task automatic beat(input logic [1:0] sel, input logic [1:0] siz, input logic [1:0] lsiz,
                        input logic [3:0] x, input logic [3:0] y, input logic [7:0] pre,
                        input logic [7:0] ori, input logic acc, input logic last,
                        input logic [8:0] lo, input logic [8:0] hi);
        exp_t e;
        @(posedge clk);
        #1;
        pre_wr_ena_i   = 1'b1;
        pre_wr_sel_i   = sel;
        pre_wr_siz_i   = siz;
        pre_wr_4x4_x_i = x;
        pre_wr_4x4_y_i = y;
        pre_wr_dat_i   = {32{pre}};
        cur_ori        = ori;
        if (acc) begin
            e.attr = {last, sel, lsiz, x, y};
            e.dat  = mk_dat(lo, hi);
            e.due  = cyc + 2;
            q.push_back(e);
        end
        #1;
        chk("ori_rd_ena", ori_rd_ena_o, acc);
        if (acc) chk("ori_rd_xy", {ori_rd_4x4_x_o, ori_rd_4x4_y_o}, {x, y});
    endtask

    task automatic idle_inputs();
        @(posedge clk);
        #1;
        pre_wr_ena_i = 1'b0;
        ctu_done_i   = 1'b0;
    endtask

    task automatic pulse(input int which, input logic expect_rec);
        @(posedge clk);
        #1;
        if (which == 0) start_i = 1'b1;
        else if (which == 1) ctu_done_i = 1'b1;
        else begin
            tq_done_i = 1'b1;
            if (expect_rec) rec_due = cyc + 1;
        end
        @(posedge clk);
        #1;
        start_i = 1'b0;
        ctu_done_i = 1'b0;
        tq_done_i = 1'b0;
    endtask

    task automatic run_tu(input int i);
        vec_t v;
        v = vecs[i];
        for (int j = 0; j < v.n; j++)
            beat(v.sel, (j == 0) ? v.siz : ~v.siz, v.siz, 4'(j), 4'((j >> 4) + i),
                 v.pre, v.ori, 1'b1, j == v.n - 1, v.lo, v.hi);
        idle_inputs();
        repeat (3) @(posedge clk);
    endtask

    initial begin
        vecs[0] = '{sel: 2'd0, siz: 2'd0, pre: 8'h10, ori: 8'h30, n: 1,  lo: 9'h020, hi: 9'h000};
        vecs[1] = '{sel: 2'd0, siz: 2'd3, pre: 8'h05, ori: 8'h07, n: 32, lo: 9'h002, hi: 9'h002};
        vecs[2] = '{sel: 2'd0, siz: 2'd1, pre: 8'hFF, ori: 8'h00, n: 2,  lo: 9'h101, hi: 9'h101};
        vecs[3] = '{sel: 2'd0, siz: 2'd1, pre: 8'h00, ori: 8'hFF, n: 2,  lo: 9'h0FF, hi: 9'h0FF};
        vecs[4] = '{sel: 2'd1, siz: 2'd1, pre: 8'h80, ori: 8'h7F, n: 2,  lo: 9'h1FF, hi: 9'h1FF};
        vecs[5] = '{sel: 2'd2, siz: 2'd2, pre: 8'h20, ori: 8'h10, n: 8,  lo: 9'h1F0, hi: 9'h1F0};
        vecs[6] = '{sel: 2'd0, siz: 2'd0, pre: 8'hFF, ori: 8'h00, n: 1,  lo: 9'h101, hi: 9'h000};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_res_val", res_val_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_rec_done", rec_done_o, 1'b0);
        chk("rst_ori_ena", ori_rd_ena_o, 1'b0);
        rstn = 1'b1;

        pulse(0, 1'b0);
        pulse(2, 1'b0);                       // tq_done in STRM must be ignored
        run_tu(0);
        beat(2'd0, 2'd0, 2'd0, 4'd5, 4'd5, 8'h11, 8'h22, 1'b0, 1'b0, 9'h0, 9'h0);
        idle_inputs();
        chk("err_after_wait_beat", err_o, 1'b1);
        pulse(2, 1'b1);
        for (int i = 1; i < 7; i++) begin
            run_tu(i);
            pulse(2, 1'b1);
            $display("tu %0d done err=%0b", i, err_o);
        end
        chk("err_sticky", err_o, 1'b1);

        pulse(1, 1'b0);
        pulse(0, 1'b0);
        chk("err_cleared_by_start", err_o, 1'b0);

        // ctu_done together with an accepted beat: the beat still drains.
        beat(2'd1, 2'd1, 2'd1, 4'd2, 4'd3, 8'h10, 8'h30, 1'b1, 1'b0, 9'h020, 9'h020);
        ctu_done_i = 1'b1;
        idle_inputs();
        beat(2'd0, 2'd0, 2'd0, 4'd0, 4'd0, 8'h00, 8'h01, 1'b0, 1'b0, 9'h0, 9'h0);
        idle_inputs();
        chk("err_after_idle_beat", err_o, 1'b1);
        repeat (4) @(posedge clk);

        // Reset in the middle of a SIZE_16 TU.
        pulse(0, 1'b0);
        for (int j = 0; j < 3; j++)
            beat(2'd0, 2'd2, 2'd2, 4'(j), 4'd1, 8'h40, 8'h41, 1'b1, 1'b0, 9'h001, 9'h001);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        pre_wr_ena_i = 1'b0;
        q.delete();
        rec_due = -1;
        #1;
        chk("mid_rst_outputs", {res_val_o, res_last_o, rec_done_o, err_o, ori_rd_ena_o}, 5'd0);
        chk("mid_rst_dat", res_dat_o, 288'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        beat(2'd0, 2'd2, 2'd2, 4'd3, 4'd1, 8'h40, 8'h41, 1'b0, 1'b0, 9'h0, 9'h0);
        idle_inputs();
        repeat (5) @(posedge clk);
        pulse(0, 1'b0);
        beat(2'd0, 2'd0, 2'd0, 4'd7, 4'd8, 8'h00, 8'h01, 1'b1, 1'b1, 9'h001, 9'h000);
        idle_inputs();
        repeat (3) @(posedge clk);
        pulse(2, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", 288'(q.size()), 288'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
